mac_datapath: RTL
=================

# mac_datapath

Datapath for the multiply-accumulate unit, driven by the MAC controller FSM. It receives the controller's `ld_a`/`ld_b`/`ld_m`/`ld_acc`/`ld_out`/`count_enb`/`count_reset` strobes and returns `CMP`. It holds an N-entry operand store that the host writes, plus the operand, product, accumulator, result and element-count registers. It computes result = Σ A[i]·B[i] over i = 0..N-1, one element per controller loop.

## Interface
Parameters:
- `DW`, 8: unsigned operand width.
- `N`, 4: vector length, ≥1.
- `AW`, max(1, clog2(N)): operand address width, derived.
- `ACCW`, 2·DW + clog2(N): accumulator/result width, derived, overflow-free.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset (already decided).
- `wr_en` in 1: host operand write strobe.
- `wr_addr` in AW: operand index; writes with `wr_addr` ≥ N are ignored.
- `wr_a`, `wr_b` in DW each: operand pair written to A[wr_addr] and B[wr_addr].
- `ld_a`, `ld_b`, `ld_m`, `ld_acc`, `ld_out`, `count_enb`, `count_reset` in 1 each: controller strobes.
- `CMP` out 1: more elements remain.
- `result` out ACCW: last completed dot product.
- `count` out AW+1: element counter, for debug and verification.

## Operation
- Reset (sync):
  - cnt=0, a_reg=b_reg=m_reg=acc=result=0.
  - CMP=1.
  - Operand store is not cleared.
- Operand store: on `wr_en`, A[wr_addr]←wr_a and B[wr_addr]←wr_b at the clock edge.
- `ld_a`: a_reg←A[cnt], using cnt as it stands before any same-cycle increment. If cnt ≥ N, a_reg←0.
- `ld_b`: same rule for b_reg.
- `ld_m`: m_reg←a_reg·b_reg, unsigned, 2·DW bits.
- `ld_acc`: acc←acc + zero-extended m_reg.
- `ld_out`: result←acc.
- `count_reset`: cnt←0 and acc←0. It has priority over `count_enb` and `ld_acc`.
- `count_enb` alone: cnt←cnt+1, saturating at N.
- `CMP` = (cnt < N), combinational from the registered cnt.
- Read-before-write: if `wr_en` and `ld_a`/`ld_b` hit the same index in the same cycle, the registers capture the old value.
- Simultaneous `ld_out` and `count_reset`: result captures the pre-clear acc; acc clears in the same edge.

## Timing
- Each strobe acts at the clock edge where it is sampled high; the updated register is visible the next cycle.
- Controller loop for one element (ld_ab → wait → ld_m → wait → ld_acc → wait) is 6 cycles. The wait states guarantee:
  - a_reg/b_reg are stable before `ld_m`.
  - m_reg is stable before `ld_acc`.
- After the k-th `ld_a`/`count_enb` edge, cnt=k.
- CMP falls the cycle after the N-th load, so the controller sees CMP=0 in its wait state and exits.
- Run of N elements, measured from the first `ld_a` cycle to the `ld_out` cycle inclusive, is 6N+1 cycles.
- `result` is valid from the cycle after the controller's `done` pulse and holds until the next `ld_out`.
- Reset mid-run aborts the accumulation; no partial value ever reaches `result`.

## Structure
- Shared package `mac_pkg` holds:
  - DW/N defaults.
  - The ACCW/AW derivation functions.
  - The controller state-encoding constants, shared with the controller.
- One sub-module, `mac_operand_mem`:
  - Two-bank N×DW register file.
  - One write port, one combinational read port indexed by cnt.
  - Out-of-range read returns 0.
- Counter, registers and adder stay in `mac_datapath`.

## Test plan
All scenarios use DW=8, N=4 with the controller attached.
- A={1,2,3,4}, B={5,6,7,8}, pulse go → CMP low after the 4th `ld_a`; result=70 in the cycle after done.
- All A=B=255 → result=260100 (0x3F804) with no wrap in the 18-bit result.
- Back-to-back: result 70, then A={1,1,1,1}, B={2,2,2,2} → second result=8, not 78 (acc cleared by `count_reset`).
- rst held high 1 cycle after 2 elements → count=0, acc=0, result=0, CMP=1; a following full run gives 70.
- `wr_en` to index 0 with wr_a=9 in the same cycle as the first `ld_a`, A[0] previously 1 → a_reg=1; the following run uses 9.
- Standalone strobes: `count_enb` ×6 → count saturates at 4; `ld_a` at count=4 → a_reg=0; `count_reset` with `count_enb` → count=0.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, derivation helpers and controller state encoding for the MAC unit
package mac_pkg;
   localparam int DW_DEF = 8;
   localparam int N_DEF  = 4;
   function automatic int calc_aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int calc_accw(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction
   typedef enum logic [2:0] {
      S_IDLE, S_LD_AB, S_WAIT_AB, S_LD_M, S_WAIT_M, S_LD_ACC, S_WAIT_ACC, S_DONE
   } mac_state_e;
endpackage

// File: rtl/mac_operand_mem.sv
// mac_operand_mem: two-bank N x DW operand store, one write port, combinational read by element index
module mac_operand_mem import mac_pkg::*; #(
   parameter int DW = DW_DEF,
   parameter int N  = N_DEF,
   parameter int AW = calc_aw(N)
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_a_i,
   input  logic [DW-1:0] wr_b_i,
   input  logic [AW:0]   rd_addr_i,
   output logic [DW-1:0] rd_a_o,
   output logic [DW-1:0] rd_b_o
);
   localparam logic [AW:0] NV = (AW + 1)'(N);
   logic [DW-1:0] mem_a_q [N];
   logic [DW-1:0] mem_b_q [N];
   // host writes land at the edge; indices beyond the store are dropped
   always_ff @(posedge clk) begin
      if (wr_en_i && ({1'b0, wr_addr_i} < NV)) begin
         mem_a_q[wr_addr_i] <= wr_a_i;
         mem_b_q[wr_addr_i] <= wr_b_i;
      end
   end
   assign rd_a_o = (rd_addr_i < NV) ? mem_a_q[rd_addr_i[AW-1:0]] : '0;
   assign rd_b_o = (rd_addr_i < NV) ? mem_b_q[rd_addr_i[AW-1:0]] : '0;
endmodule

// File: rtl/mac_datapath.sv
// mac_datapath: operand/product/accumulator/result registers and element counter for the MAC unit
module mac_datapath import mac_pkg::*; #(
   parameter int DW   = DW_DEF,
   parameter int N    = N_DEF,
   parameter int AW   = calc_aw(N),
   parameter int ACCW = calc_accw(DW, N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_a,
   input  logic [DW-1:0]   wr_b,
   input  logic            ld_a,
   input  logic            ld_b,
   input  logic            ld_m,
   input  logic            ld_acc,
   input  logic            ld_out,
   input  logic            count_enb,
   input  logic            count_reset,
   output logic            CMP,
   output logic [ACCW-1:0] result,
   output logic [AW:0]     count
);
   localparam logic [AW:0] NV = (AW + 1)'(N);
   logic [AW:0]     cnt_q, cnt_d;
   logic [DW-1:0]   a_q, a_d, b_q, b_d, rd_a, rd_b;
   logic [2*DW-1:0] m_q, m_d;
   logic [ACCW-1:0] acc_q, acc_d, result_q, result_d;
   mac_operand_mem #(.DW(DW), .N(N), .AW(AW)) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_a_i    (wr_a),
      .wr_b_i    (wr_b),
      .rd_addr_i (cnt_q),
      .rd_a_o    (rd_a),
      .rd_b_o    (rd_b)
   );
   // count_reset wins over both count_enb and ld_acc; the read uses the pre-increment count
   always_comb begin
      cnt_d    = count_reset ? '0 : (count_enb && cnt_q < NV) ? cnt_q + 1'b1 : cnt_q;
      a_d      = ld_a ? rd_a : a_q;
      b_d      = ld_b ? rd_b : b_q;
      m_d      = ld_m ? {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q} : m_q;
      acc_d    = count_reset ? '0 : ld_acc ? acc_q + ACCW'(m_q) : acc_q;
      result_d = ld_out ? acc_q : result_q;
   end
   // state registers; the operand store deliberately survives reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end
   assign CMP    = cnt_q < NV;
   assign result = result_q;
   assign count  = cnt_q;
endmodule
